// File: rtl/hub75_scan_controller_pkg.sv
// hub75_pkg: shared defaults, FSM state codes and the BCM on-time helper for the HUB75 scan controller
package hub75_pkg;
  localparam int COLUMNS_DEF = 32;
  localparam int ROW_BITS_DEF = 3;
  localparam int DEPTH_DEF = 4;
  localparam int BASE_TIME_DEF = 8;
  localparam int COL_BITS = $clog2(COLUMNS_DEF);
  localparam int ADDR_W = ROW_BITS_DEF + COL_BITS;
  localparam int TIMER_W = $clog2(BASE_TIME_DEF << (DEPTH_DEF - 1)) + 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREFETCH = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  function automatic int bcm_time(input int base, input int plane);
    return base << plane;
  endfunction
endpackage

// File: rtl/hub75_scan_controller_if.sv
// hub75_scan_controller_if: framebuffer read port plus HUB75 panel pins
interface hub75_scan_controller_if #(
  parameter int ADDR_W = hub75_pkg::ADDR_W,
  parameter int DATA_W = 6 * hub75_pkg::DEPTH_DEF,
  parameter int ROW_BITS = hub75_pkg::ROW_BITS_DEF
);
  logic fb_rd;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic [5:0] rgb;
  logic [ROW_BITS-1:0] a;
  logic oe;
  logic lat;
  logic oclk;
  modport master(output fb_rd, fb_addr, rgb, a, oe, lat, oclk, input fb_data);
  modport slave(input fb_rd, fb_addr, rgb, a, oe, lat, oclk, output fb_data);
endinterface

// File: rtl/hub75_scan_controller_bcm_timer.sv
// hub75_bcm_timer: down-counter that holds the panel enabled for a loaded number of cycles
module hub75_bcm_timer #(
  parameter int W = hub75_pkg::TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] count_i,
  output logic         busy_o,
  output logic         oe_n_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign busy_o = cnt_q != '0;
  assign oe_n_o = ~busy_o;
  assign cnt_d = load_i ? count_i : busy_o ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/hub75_scan_controller.sv
// hub75_scan_controller: fetches pixel pairs, shifts one bit plane per row, latches and BCM-gates the panel
module hub75_scan_controller
  import hub75_pkg::*;
#(
  parameter int COLUMNS = COLUMNS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int BASE_TIME = BASE_TIME_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  hub75_scan_controller_if.master bus,
  output logic frame_start_o,
  output logic busy_o
);
  localparam int COL_W = $clog2(COLUMNS);
  localparam int PLANE_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int TMR_W = $clog2(BASE_TIME << (DEPTH - 1)) + 1;
  logic [2:0] state_q, state_d;
  logic [ROW_BITS-1:0] row_q, a_q;
  logic [PLANE_W-1:0] plane_q;
  logic [COL_W-1:0] col_q;
  logic phase_q;
  logic [5:0] rgb_q, rgb_d;
  logic tmr_busy, last_col, last_plane, in_shift, in_latch;
  assign in_shift = state_q == S_SHIFT;
  assign in_latch = state_q == S_LATCH;
  assign last_col = in_shift && phase_q && col_q == COL_W'(COLUMNS - 1);
  assign last_plane = plane_q == PLANE_W'(DEPTH - 1);
  always_comb begin
    rgb_d = '0;
    for (int i = 0; i < 6; i++) rgb_d[i] = bus.fb_data[i*DEPTH + int'(plane_q)];
  end
  // Enable is only consulted when a new plane would start, so a running plane always completes
  always_comb
    state_d = state_q == S_IDLE     ? (enable_i ? S_PREFETCH : S_IDLE) :
              state_q == S_PREFETCH ? S_SHIFT :
              in_shift              ? (last_col ? (tmr_busy ? S_WAIT : S_LATCH) : S_SHIFT) :
              state_q == S_WAIT     ? (tmr_busy ? S_WAIT : S_LATCH) :
              enable_i              ? S_PREFETCH : S_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      row_q <= '0;
      a_q <= '0;
      plane_q <= '0;
      col_q <= '0;
      phase_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_shift) begin
        phase_q <= ~phase_q;
        if (phase_q) col_q <= col_q + 1'b1;
        else rgb_q <= rgb_d;
      end
      if (in_latch) begin
        a_q <= row_q;
        plane_q <= last_plane ? '0 : plane_q + 1'b1;
        if (last_plane) row_q <= row_q + 1'b1;
      end
    end
  // Column c+1 is requested during phase 1 of column c so its data is ready for the next phase 0
  assign bus.fb_rd = state_q == S_PREFETCH || (in_shift && phase_q && !last_col);
  assign bus.fb_addr = {row_q, in_shift ? COL_W'(col_q + 1'b1) : COL_W'(0)};
  assign bus.rgb = rgb_q;
  assign bus.a = a_q;
  assign bus.lat = in_latch;
  assign bus.oclk = in_shift && phase_q;
  assign frame_start_o = in_latch && row_q == '0 && plane_q == '0;
  assign busy_o = state_q != S_IDLE;
  hub75_bcm_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (in_latch),
    .count_i(TMR_W'(bcm_time(BASE_TIME, int'(plane_q)))),
    .busy_o (tmr_busy),
    .oe_n_o (bus.oe)
  );
endmodule

// File: tb/tb_hub75_scan_controller.sv
// tb_hub75_scan_controller: scoreboard bench for the default build and a long-BASE_TIME build
module tb_hub75_scan_controller;
  logic clk = 1'b0;
  logic rst = 1'b1, rst1 = 1'b1, en = 1'b0, en1 = 1'b0;
  logic fs0, busy0, fs1, busy1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  hub75_scan_controller_if #(.ADDR_W(8), .DATA_W(24), .ROW_BITS(3)) bus0 ();
  hub75_scan_controller_if #(.ADDR_W(8), .DATA_W(24), .ROW_BITS(3)) bus1 ();
  hub75_scan_controller dut0 (.clk(clk), .rst(rst), .enable_i(en), .bus(bus0), .frame_start_o(fs0), .busy_o(busy0));
  hub75_scan_controller #(.BASE_TIME(64)) dut1 (.clk(clk), .rst(rst1), .enable_i(en1), .bus(bus1), .frame_start_o(fs1), .busy_o(busy1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] fb_word(input logic [7:0] ad);
    logic [23:0] w;
    int r, c;
    r = int'(ad[7:5]);
    c = int'(ad[4:0]);
    for (int i = 0; i < 6; i++) w[i*4+:4] = 4'(c) ^ 4'(i == 5 ? r * 6 : i * 7 + r * 3);
    return w;
  endfunction
  function automatic logic [5:0] plane_bits(input logic [23:0] w, input int p);
    logic [5:0] b;
    for (int i = 0; i < 6; i++) b[i] = w[i*4+p];
    return b;
  endfunction
  logic [2:0] mdl_row;
  int mdl_plane, rd_idx, oclk_since, on_run, lat_count;
  logic a_pend, oclk_prev, pend;
  logic [2:0] a_exp;
  logic [7:0] pend_addr;
  logic [5:0] rgb_sb[$];
  int on_q[$];
  always @(posedge clk)
    if (pend && !rst) begin
      #1;
      bus0.fb_data = fb_word(pend_addr);
      rgb_sb.push_back(plane_bits(bus0.fb_data, mdl_plane));
    end
  always @(negedge clk)
    if (rst) begin
      mdl_row = '0;
      mdl_plane = 0;
      rd_idx = 0;
      oclk_since = 0;
      on_run = 0;
      lat_count = 0;
      a_pend = 1'b0;
      oclk_prev = 1'b0;
      pend = 1'b0;
      rgb_sb.delete();
      on_q.delete();
    end else begin
      if (a_pend) chk("a_after_lat", bus0.a, a_exp);
      a_pend = 1'b0;
      if (!bus0.oe) on_run++;
      else if (on_run > 0) begin
        if (on_q.size() > 0) chk("bcm_on_time", on_run, on_q.pop_front());
        else chk("on_time_unexpected", on_q.size(), 1);
        on_run = 0;
      end
      if (bus0.lat) begin
        chk("lat_oe_blank", bus0.oe, 1'b1);
        chk("frame_start", fs0, mdl_row == 0 && mdl_plane == 0);
        chk("oclk_per_plane", oclk_since, 32);
        on_q.push_back(8 << mdl_plane);
        a_pend = 1'b1;
        a_exp = mdl_row;
        if (mdl_plane == 3) begin
          mdl_plane = 0;
          mdl_row++;
        end else mdl_plane++;
        oclk_since = 0;
        rd_idx = 0;
        lat_count++;
      end else if (fs0) chk("frame_start_no_lat", fs0, 1'b0);
      pend = bus0.fb_rd;
      if (bus0.fb_rd) begin
        chk("fb_addr", bus0.fb_addr, {mdl_row, 5'(rd_idx)});
        pend_addr = bus0.fb_addr;
        rd_idx++;
      end
      if (bus0.oclk && !oclk_prev) begin
        oclk_since++;
        if (rgb_sb.size() > 0) chk("rgb", bus0.rgb, rgb_sb.pop_front());
        else chk("rgb_sb_empty", rgb_sb.size(), 1);
      end
      oclk_prev = bus0.oclk;
    end
  task automatic wait_lat(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.lat && n < bound);
    if (!bus0.lat) chk("lat_timeout", n, 0);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_oe"}, bus0.oe, 1'b1);
    chk({tag, "_lat"}, bus0.lat, 1'b0);
    chk({tag, "_oclk"}, bus0.oclk, 1'b0);
    chk({tag, "_fb_rd"}, bus0.fb_rd, 1'b0);
    chk({tag, "_rgb"}, bus0.rgb, 6'd0);
    chk({tag, "_a"}, bus0.a, 3'd0);
    chk({tag, "_busy"}, busy0, 1'b0);
    chk({tag, "_fs"}, fs0, 1'b0);
  endtask
  initial begin
    int n, k, lows, rds, since, oclk_hi, lats, plane1;
    int gap_q[$];
    bus0.fb_data = '0;
    bus1.fb_data = '0;
    repeat (3) @(negedge clk);
    reset_checks("rst_init");
    #2 rst = 1'b0;
    en = 1'b1;
    wait_lat(200, n);
    chk("first_lat_cycle", n, 66);
    k = 0;
    while (lat_count < 33 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("frame_wrap_lats", lat_count >= 33, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus0.oclk && k < 200);
    chk("reached_shift", bus0.oclk, 1'b1);
    #2 rst = 1'b1;
    #1 reset_checks("rst_mid_shift");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_lat(200, n);
    chk("relat_cycle", n, 66);
    k = 0;
    while (lat_count < 2 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    #2 en = 1'b0;
    wait_lat(200, n);
    lows = 0;
    rds = 0;
    repeat (80) begin
      @(negedge clk);
      if (!bus0.oe) lows++;
      if (bus0.fb_rd) rds++;
    end
    chk("drop_plane2_on", lows, 32);
    chk("drop_no_fb_rd", rds, 0);
    chk("drop_idle_busy", busy0, 1'b0);
    chk("drop_idle_oe", bus0.oe, 1'b1);
    @(negedge clk);
    #2 rst1 = 1'b0;
    en1 = 1'b1;
    gap_q.push_back(66);
    since = 0;
    oclk_hi = 0;
    lats = 0;
    plane1 = 0;
    k = 0;
    while (lats < 5 && k < 3000) begin
      @(negedge clk);
      k++;
      since++;
      if (bus1.oclk) oclk_hi++;
      if (bus1.lat) begin
        chk("wait_lat_oe_blank", bus1.oe, 1'b1);
        chk("wait_lat_gap", since, gap_q.pop_front());
        chk("wait_oclk_high", oclk_hi, 32);
        gap_q.push_back(((64 << plane1) + 2) > 66 ? (64 << plane1) + 2 : 66);
        plane1 = (plane1 + 1) % 4;
        since = 0;
        oclk_hi = 0;
        lats++;
      end
    end
    if (lats < 5) chk("wait_timeout", lats, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
